// File: rtl/bitonic_sort_seq_if.sv
// Valid/ready job interface for bitonic_sort_seq: one K x W-bit array in,
// the sorted array (plus adjacent-duplicate flags) out.
interface bitonic_sort_seq_if #(
  parameter int unsigned W = 3,
  parameter int unsigned K = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W*K-1:0]   in_array;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [W*K-1:0]   out_array;
  logic [K-2:0]     out_dup;

  // Job source / result sink side
  modport master (
    output in_valid, in_array, in_dir, out_ready,
    input  in_ready, out_valid, out_array, out_dup
  );

  // Sorter side
  modport slave (
    input  in_valid, in_array, in_dir, out_ready,
    output in_ready, out_valid, out_array, out_dup
  );
endinterface

// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: accepts one K-entry array per job, applies one
// compare-exchange stage per clock with K/2 comparators, then holds the
// result until the downstream handshake completes.
// Optional feature macro: PSI_DUP_FLAG_EN (adjacent-duplicate flags on out_dup).
module bitonic_sort_seq #(
  parameter int unsigned W = 3,
  parameter int unsigned K = 8
) (
  input  logic               clk,
  input  logic               rst,
  bitonic_sort_seq_if.slave  bus
);

  localparam int unsigned L  = $clog2(K);
  localparam int unsigned S  = L * (L + 1) / 2;
  localparam int unsigned SW = $clog2(S + 1);
  localparam int unsigned LW = $clog2(L + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    data_q [K];
  logic [W-1:0]    data_d [K];
  logic [W-1:0]    staged_c [K];
  logic            dir_q, dir_d;
  logic [SW-1:0]   stage_q, stage_d;
  // log2 of the current (k, j) pair of the stage being applied
  logic [LW-1:0]   k_log_q, k_log_d;
  logic [LW-1:0]   j_log_q, j_log_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    cx_a, cx_b;
  logic            cx_asc;

  // One bitonic compare-exchange stage on the data register
  always_comb begin
    cx_a   = '0;
    cx_b   = '0;
    cx_asc = 1'b0;
    for (int i = 0; i < K; i++) staged_c[i] = data_q[i];
    for (int jj = 0; jj < L; jj++) begin
      if (j_log_q == LW'(jj)) begin
        for (int i = 0; i < K; i++) begin
          if (((i >> jj) & 1) == 0) begin
            cx_a   = data_q[i];
            cx_b   = data_q[i + (1 << jj)];
            cx_asc = ((((i >> k_log_q) & 1) == 0) ? 1'b1 : 1'b0) ^ dir_q;
            // Equal pairs never swap: strict comparisons only
            if (cx_asc ? (cx_a > cx_b) : (cx_a < cx_b)) begin
              staged_c[i]             = cx_b;
              staged_c[i + (1 << jj)] = cx_a;
            end
          end
        end
      end
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    stage_d = stage_q;
    k_log_d = k_log_q;
    j_log_d = j_log_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          for (int e = 0; e < K; e++) data_d[e] = bus.in_array[W*(K-e)-1 -: W];
          dir_d   = bus.in_dir;
          stage_d = '0;
          k_log_d = LW'(1);
          j_log_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        data_d  = staged_c;
        stage_d = stage_q + SW'(1);
        if (stage_q == SW'(S - 1)) begin
          state_d = DONE;
        end else if (j_log_q == '0) begin
          // Next k doubles; its first j is k/2, i.e. log2 equals the old k
          k_log_d = k_log_q + LW'(1);
          j_log_d = k_log_q;
        end else begin
          j_log_d = j_log_q - LW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      for (int e = 0; e < K; e++) data_q[e] <= '0;
      dir_q       <= 1'b0;
      stage_q     <= '0;
      k_log_q     <= '0;
      j_log_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      stage_q     <= stage_d;
      k_log_q     <= k_log_d;
      j_log_q     <= j_log_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // Result array straight from the data register
  for (genvar e = 0; e < K; e++) begin : g_out
    assign bus.out_array[W*(K-e)-1 -: W] = data_q[e];
  end

`ifdef PSI_DUP_FLAG_EN
  // Adjacent-equal flags on the sorted array, visible only with a result
  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      bus.out_dup[i] = out_valid_q && (data_q[i] == data_q[i+1]);
    end
  end
`else
  assign bus.out_dup = '0;
`endif

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Self-checking bench for bitonic_sort_seq (K=8/W=3 and K=2/W=8 instances).
module tb_bitonic_sort_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bitonic_sort_seq_if #(.W(3), .K(8)) b8 ();
  bitonic_sort_seq_if #(.W(8), .K(2)) b2 ();

  bitonic_sort_seq #(.W(3), .K(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  bitonic_sort_seq #(.W(8), .K(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_arr_q [$];
  logic [6:0]  exp_dup_q [$];
  logic [23:0] last_exp;
  logic [6:0]  last_dup;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain bubble sort on unpacked elements (element 0 = MSB slice)
  function automatic logic [23:0] ref_sort(input logic [23:0] a, input logic dir);
    logic [2:0] e [8];
    logic [2:0] t;
    logic [23:0] r;
    for (int i = 0; i < 8; i++) e[i] = a[3*(7-i) +: 3];
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 7; i++) begin
        if (dir ? (e[i] < e[i+1]) : (e[i] > e[i+1])) begin
          t = e[i]; e[i] = e[i+1]; e[i+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[3*(7-i) +: 3] = e[i];
    return r;
  endfunction

  function automatic logic [6:0] dup8(input logic [23:0] a);
    logic [6:0] d;
    d = '0;
`ifdef PSI_DUP_FLAG_EN
    for (int i = 0; i < 7; i++) d[i] = (a[3*(7-i) +: 3] == a[3*(6-i) +: 3]);
`endif
    return d;
  endfunction

  task automatic start8(input logic [23:0] arr, input logic dir, input logic [23:0] exp);
    chk("k8_in_ready_pre", 64'(b8.in_ready), 64'(1));
    b8.in_valid = 1'b1;
    b8.in_array = arr;
    b8.in_dir   = dir;
    exp_arr_q.push_back(exp);
    exp_dup_q.push_back(dup8(exp));
    tick();
    b8.in_valid = 1'b0;
    chk("k8_in_ready_busy", 64'(b8.in_ready), 64'(0));
  endtask

  task automatic wait8(input string tag);
    int lat;
    lat = 0;
    while (!b8.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_out_valid"}, 64'(b8.out_valid), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(6));
    chk({tag, "_sb_nonempty"}, 64'(exp_arr_q.size() > 0), 64'(1));
    if (exp_arr_q.size() > 0) begin
      last_exp = exp_arr_q.pop_front();
      last_dup = exp_dup_q.pop_front();
      chk({tag, "_array"}, 64'(b8.out_array), 64'(last_exp));
      chk({tag, "_dup"}, 64'(b8.out_dup), 64'(last_dup));
    end
  endtask

  task automatic finish8(input string tag);
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 64'(b8.in_ready), 64'(1));
    chk({tag, "_out_valid_after"}, 64'(b8.out_valid), 64'(0));
    chk({tag, "_dup_after"}, 64'(b8.out_dup), 64'(0));
  endtask

  task automatic job2(input string tag, input logic [15:0] arr, input logic dir,
                      input logic [15:0] exp, input logic exp_dup);
    int lat;
    chk({tag, "_in_ready_pre"}, 64'(b2.in_ready), 64'(1));
    b2.in_valid = 1'b1;
    b2.in_array = arr;
    b2.in_dir   = dir;
    tick();
    b2.in_valid = 1'b0;
    lat = 0;
    while (!b2.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(1));
    chk({tag, "_array"}, 64'(b2.out_array), 64'(exp));
    chk({tag, "_dup"}, 64'(b2.out_dup), 64'(exp_dup));
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 64'(b2.in_ready), 64'(1));
  endtask

  logic [23:0] base_arr, dup_arr, ra;
  logic [6:0]  dup_const;
  logic        rd;

  initial begin
    rst = 1'b0;
    b8.in_valid = 1'b0; b8.in_array = '0; b8.in_dir = 1'b0; b8.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_array = '0; b2.in_dir = 1'b0; b2.out_ready = 1'b0;
    tick();
    tick();

    // Reset state of both instances
    chk("rst_k8_in_ready",  64'(b8.in_ready),  64'(1));
    chk("rst_k8_out_valid", 64'(b8.out_valid), 64'(0));
    chk("rst_k8_out_array", 64'(b8.out_array), 64'(0));
    chk("rst_k8_out_dup",   64'(b8.out_dup),   64'(0));
    chk("rst_k2_in_ready",  64'(b2.in_ready),  64'(1));
    chk("rst_k2_out_valid", 64'(b2.out_valid), 64'(0));
    chk("rst_k2_out_array", 64'(b2.out_array), 64'(0));
    rst = 1'b1;
    tick();

    // Descending sort
    base_arr = {3'd1, 3'd6, 3'd5, 3'd3, 3'd7, 3'd0, 3'd2, 3'd4};
    start8(base_arr, 1'b1, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    wait8("desc");
    finish8("desc");

    // Ascending sort, accepted on first out_valid, then a back-to-back job
    start8(base_arr, 1'b0, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
    wait8("asc");
    finish8("asc");
    dup_arr = {3'd3, 3'd3, 3'd5, 3'd0, 3'd5, 3'd1, 3'd7, 3'd3};
    start8(dup_arr, 1'b0, {3'd0, 3'd1, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd7});
    wait8("dups");
`ifdef PSI_DUP_FLAG_EN
    dup_const = 7'b0101100;
`else
    dup_const = 7'b0000000;
`endif
    chk("dups_const_flags", 64'(b8.out_dup), 64'(dup_const));
    finish8("dups");

    // Backpressure with input noise
    ra = 24'($urandom);
    start8(ra, 1'b1, ref_sort(ra, 1'b1));
    wait8("bp");
    for (int c = 0; c < 10; c++) begin
      b8.in_valid = 1'($urandom);
      b8.in_array = 24'($urandom);
      b8.in_dir   = 1'($urandom);
      tick();
      chk("bp_hold_array", 64'(b8.out_array), 64'(last_exp));
      chk("bp_hold_dup",   64'(b8.out_dup),   64'(last_dup));
      chk("bp_in_ready",   64'(b8.in_ready),  64'(0));
      chk("bp_out_valid",  64'(b8.out_valid), 64'(1));
    end
    b8.in_valid = 1'b0;
    finish8("bp");

    // Reset during stage 3 aborts the job
    ra = 24'($urandom);
    start8(ra, 1'b0, ref_sort(ra, 1'b0));
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("abort_in_ready",  64'(b8.in_ready),  64'(1));
    chk("abort_out_valid", 64'(b8.out_valid), 64'(0));
    chk("abort_out_array", 64'(b8.out_array), 64'(0));
    chk("abort_out_dup",   64'(b8.out_dup),   64'(0));
    void'(exp_arr_q.pop_back());
    void'(exp_dup_q.pop_back());
    tick();
    rst = 1'b1;
    #2;
    start8(base_arr, 1'b1, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    wait8("post_rst");
    finish8("post_rst");

    // Random back-to-back jobs against the reference sort
    for (int n = 0; n < 4; n++) begin
      ra = 24'($urandom);
      rd = 1'(n);
      start8(ra, rd, ref_sort(ra, rd));
      wait8("rand");
      finish8("rand");
    end

    // Degenerate K = 2, W = 8
    job2("k2_desc", {8'h10, 8'hF0}, 1'b1, {8'hF0, 8'h10}, 1'b0);
    job2("k2_asc",  {8'hF0, 8'h10}, 1'b0, {8'h10, 8'hF0}, 1'b0);
`ifdef PSI_DUP_FLAG_EN
    job2("k2_equal", {8'h55, 8'h55}, 1'b1, {8'h55, 8'h55}, 1'b1);
`else
    job2("k2_equal", {8'h55, 8'h55}, 1'b1, {8'h55, 8'h55}, 1'b0);
`endif

    chk("sb_drained", 64'(exp_arr_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_seq.md
# bitonic_sort_seq

Sequential, parametrised successor to the combinational bitonic sorter in the PSI flow. It accepts one K-element array of W-bit unsigned entries per job over a valid/ready handshake. It sorts the array in place, one bitonic compare-exchange stage per clock, using K/2 comparators. It presents the sorted array to the downstream PSI intersection logic over a second valid/ready handshake, optionally with adjacent-duplicate flags.

## Interface
- W, default 3: bit width of each entry (unsigned).
- K, default 8: entries per array; a power of two, K ≥ 2.
- Derived L = log2(K); S = L*(L+1)/2 stages (S = 6 for K = 8).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_array/in_dir valid.
- in_ready  out  1  block can accept a job.
- in_array  in  W*K  element e at bits [W*(K-e)-1 : W*(K-e-1)]; element 0 is the MSB slice.
- in_dir  in  1  1 = descending (element 0 largest), 0 = ascending.
- out_valid  out  1  out_array holds a finished sort.
- out_ready  in  1  downstream accepts result.
- out_array  out  W*K  sorted array, same element packing as in_array.
- out_dup  out  K-1  bit i set when sorted element i equals element i+1.

## Operation
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch in_array into the data register and in_dir into a dir register. Clear the stage counter. Go to SORT.
  - SORT: in_ready = 0, out_valid = 0. Each cycle, apply stage counter value s (0..S-1) to the data register, then increment. After the edge that applies stage S-1, go to DONE.
  - DONE: out_valid = 1. The data register and out_dup are held stable. On out_valid && out_ready, go to IDLE.
- Stage order: for k = 2, 4, …, K; for j = k/2, k/4, …, 1. Stage s is the s-th (k, j) pair in this order.
- Within a stage, for every index i with (i & j) == 0, compare elements i and i+j.
  - Target order is ascending when ((i & k) == 0) XOR dir, descending otherwise.
  - Swap only when the pair violates the target order. Equal pairs are never swapped.
- Comparisons are unsigned, full W bits. No arithmetic widening.
- out_array is driven directly from the data register in every state. Its value is meaningful only while out_valid = 1.
- out_dup is computed combinationally from the data register and gated by out_valid; it is 0 whenever out_valid = 0.
- in_array and in_dir are ignored outside IDLE.
- A change of in_dir while a job is in SORT or DONE has no effect on that job.

## Timing
- Reset values: state IDLE, data register 0, dir 0, stage counter 0, in_ready 1, out_valid 0, out_array 0, out_dup 0.
- Latency: out_valid rises exactly S cycles after the accept edge.
- Handshake:
  - No bypass. After the out handshake edge, in_ready is 1 in the following cycle.
  - A new job can be accepted at the earliest one cycle after result acceptance.
  - Throughput is one job per S+2 cycles with no backpressure.
- Backpressure: out_ready may stay low indefinitely. out_array and out_dup hold, and in_ready stays 0.
- A reset asserted mid-SORT or in DONE aborts the job immediately, with no output handshake. All registers return to their reset values asynchronously.
- K = 2: S = 1; a single stage with k = 2, j = 1.

## Configuration
- PSI_DUP_FLAG_EN:
  - Defined: duplicate-detect comparators are compiled in, and out_dup behaves as specified.
  - Undefined: the comparators are omitted and out_dup is tied to 0. The port list is unchanged.

## Test plan
- Descending sort, K = 8, W = 3: in_array = {1,6,5,3,7,0,2,4} (element 0 first), in_dir = 1 → out_valid exactly 6 cycles after accept, out_array = {7,6,5,4,3,2,1,0}, out_dup = 0.
- Ascending sort: same array, in_dir = 0 → out_array = {0,1,2,3,4,5,6,7}.
  - The result is accepted at the first out_valid cycle.
  - in_ready is 1 on the next cycle.
  - A back-to-back job is accepted on that next cycle.
- Duplicates: {3,3,5,0,5,1,7,3}, in_dir = 0 → out_array = {0,1,3,3,3,5,5,7}.
  - With PSI_DUP_FLAG_EN: out_dup = 7'b0101100 (bits 2, 3, 5 set).
  - Without it: out_dup = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid, while toggling in_valid, in_array and in_dir.
  - out_array is stable and in_ready stays 0.
  - After out_ready = 1 for one cycle, the FSM returns to IDLE.
- Reset mid-operation: drop rst during stage 3 → all outputs 0 and in_ready = 1 while in reset. After release, a new job sorts correctly.
- Degenerate K = 2, W = 8: {0x10, 0xF0}, in_dir = 1 → {0xF0, 0x10} with out_valid 1 cycle after accept. Equal inputs {0x55, 0x55} → unchanged, out_dup = 1 when the macro is enabled.
